// File: rtl/life_engine.sv
// Game of Life generation engine: displayed board plus shadow bank, one cell
// evaluated per clock, whole generation committed in a single cycle.
module life_engine #(
   parameter int unsigned BIT_WIDTH      = 3,
   parameter int unsigned BIT_HEIGHT     = 3,
   parameter int unsigned FRAMES_PER_GEN = 60,
   localparam int unsigned AW            = BIT_WIDTH + BIT_HEIGHT,
   localparam int unsigned SIZE          = 1 << AW,
   parameter logic [SIZE-1:0] INIT_PATTERN = 64'h0000_0000_0000_0008
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            frame_tick,
   input  logic            run,
   input  logic            step,
   input  logic            load_en,
   input  logic [SIZE-1:0] load_data,
   input  logic [AW-1:0]   rd_addr,
   output logic            rd_cell,
   output logic            busy,
   output logic            gen_done,
   output logic [15:0]     gen_count
);

   localparam int unsigned WIDTH  = 1 << BIT_WIDTH;
   localparam int unsigned HEIGHT = 1 << BIT_HEIGHT;
   localparam int unsigned FCW    = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   state_t                state, state_nx;
   logic [SIZE-1:0]       cur, nxt;
   logic [FCW-1:0]        fcnt;
   logic [AW-1:0]         idx;
   logic                  start_c;
   logic [3:0]            nbr_c;
   logic                  new_cell_c;
   logic [BIT_HEIGHT-1:0] row_c;
   logic [BIT_WIDTH-1:0]  col_c;

   assign rd_cell = cur[rd_addr];
   assign row_c   = idx[AW-1:BIT_WIDTH];
   assign col_c   = idx[BIT_WIDTH-1:0];

   // Live-neighbour count of cell idx; off-board positions count as dead.
   always_comb begin
      int r;
      int c;
      r     = 0;
      c     = 0;
      nbr_c = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            r = int'(row_c) + dr;
            c = int'(col_c) + dc;
            if ((dr != 0 || dc != 0) && r >= 0 && r < int'(HEIGHT) &&
                c >= 0 && c < int'(WIDTH))
               nbr_c = nbr_c + 4'(cur[AW'(r * int'(WIDTH) + c)]);
         end
      end
      new_cell_c = cur[idx] ? (nbr_c == 4'd2 || nbr_c == 4'd3) : (nbr_c == 4'd3);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state; a load in the same cycle as a start suppresses the generation.
   always_comb begin
      state_nx = state;
      start_c  = step | (run & frame_tick & (fcnt == FCW'(FRAMES_PER_GEN - 1)));
      case (state)
         IDLE:    if (!load_en && start_c) state_nx = COMPUTE;
         COMPUTE: if (idx == AW'(SIZE - 1)) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= INIT_PATTERN;
         nxt       <= '0;
         fcnt      <= '0;
         idx       <= '0;
         busy      <= 1'b0;
         gen_done  <= 1'b0;
         gen_count <= '0;
      end else begin
         busy     <= (state_nx != IDLE);
         gen_done <= (state == COMMIT);
         case (state)
            IDLE: begin
               if (load_en) begin
                  cur  <= load_data;
                  fcnt <= '0;
               end else if (start_c) begin
                  fcnt <= '0;
                  idx  <= '0;
               end else if (run && frame_tick) begin
                  fcnt <= fcnt + FCW'(1);
               end
            end
            COMPUTE: begin
               nxt[idx] <= new_cell_c;
               idx      <= idx + AW'(1);
            end
            COMMIT: begin
               cur       <= nxt;
               gen_count <= gen_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: directed and randomized boards checked against a
// grid-based Game of Life reference model.
module tb_life_engine;

   logic        clk;
   logic        rst_n;
   logic        frame_tick;
   logic        run;
   logic        step;
   logic        load_en;
   logic [63:0] load_data;
   logic [5:0]  rd_addr;
   logic        rd_cell;
   logic        busy;
   logic        gen_done;
   logic [15:0] gen_count;

   int          n_checks;
   int          n_fail;
   logic [63:0] model_board;
   int          exp_gc;

   life_engine #(
      .BIT_WIDTH     (3),
      .BIT_HEIGHT    (3),
      .FRAMES_PER_GEN(2),
      .INIT_PATTERN  (64'h0000_0000_0000_0008)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_tick(frame_tick),
      .run       (run),
      .step      (step),
      .load_en   (load_en),
      .load_data (load_data),
      .rd_addr   (rd_addr),
      .rd_cell   (rd_cell),
      .busy      (busy),
      .gen_done  (gen_done),
      .gen_count (gen_count)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] life_ref(input logic [63:0] b);
      bit          g[8][8];
      logic [63:0] o;
      int          n;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            g[r][c] = b[r*8+c];
      o = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int rr = r - 1; rr <= r + 1; rr++)
               for (int cc = c - 1; cc <= c + 1; cc++)
                  if (!(rr == r && cc == c) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                     if (g[rr][cc]) n++;
            o[r*8+c] = (n == 3) || (g[r][c] && n == 2);
         end
      end
      return o;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sweeps all cells, eight reads per cycle, all away from the clock edge.
   task automatic read_board(output logic [63:0] b);
      b = '0;
      for (int i = 0; i < 64; i++) begin
         if (i % 8 == 0) tick();
         rd_addr = 6'(i);
         #1;
         b[i] = rd_cell;
      end
      tick();
   endtask

   task automatic load_board(input logic [63:0] d);
      logic [63:0] obs;
      int          a;
      load_data = d;
      load_en   = 1'b1;
      tick();
      load_en = 1'b0;
      a       = $urandom_range(0, 63);
      rd_addr = 6'(a);
      #1;
      check("load_next_cycle", rd_cell, d[a]);
      model_board = d;
      read_board(obs);
      check("load_board", obs, d);
   endtask

   // One generation by step; kind: 0 none, 1 step, 2 load_en, 3 frame_tick, 4 drop run.
   task automatic run_gen(input int kind, input int inj_at, input bit also_tick);
      logic [63:0] pre;
      logic [63:0] exp;
      logic [63:0] obs;
      pre = model_board;
      exp = life_ref(pre);
      if (kind == 3 || kind == 4 || also_tick) run = 1'b1;
      step       = 1'b1;
      frame_tick = also_tick;
      tick();
      step       = 1'b0;
      frame_tick = 1'b0;
      for (int k = 0; k <= 64; k++) begin
         if (k == inj_at) begin
            case (kind)
               1: step = 1'b1;
               2: begin load_data = {$urandom, $urandom}; load_en = 1'b1; end
               3: frame_tick = 1'b1;
               4: run = 1'b0;
               default: ;
            endcase
         end
         rd_addr = 6'(k % 64);
         #1;
         check("read_isolation", rd_cell, pre[k%64]);
         check("busy_during_gen", busy, 1);
         tick();
         step       = 1'b0;
         load_en    = 1'b0;
         frame_tick = 1'b0;
      end
      exp_gc++;
      check("gen_done_latency", gen_done, 1);
      check("busy_after_commit", busy, 0);
      check("gen_count", gen_count, 64'(exp_gc));
      tick();
      check("gen_done_one_pulse", gen_done, 0);
      repeat (3) tick();
      check("no_queued_request", busy, 0);
      run         = 1'b0;
      model_board = exp;
      read_board(obs);
      check("board_after_gen", obs, exp);
   endtask

   initial begin
      logic [63:0] obs;
      logic [63:0] d;
      int          pulses;
      clk        = 1'b0;
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      run        = 1'b0;
      step       = 1'b0;
      load_en    = 1'b0;
      load_data  = '0;
      rd_addr    = '0;
      n_checks   = 0;
      n_fail     = 0;
      exp_gc     = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_gen_done", gen_done, 0);
      check("reset_gen_count", gen_count, 0);
      rst_n = 1'b1;
      model_board = 64'h8;
      read_board(obs);
      check("reset_board", obs, 64'h8);

      // Blinker oscillates between horizontal and vertical
      load_board((64'd1 << 9) | (64'd1 << 10) | (64'd1 << 11));
      run_gen(0, -1, 1'b0);
      read_board(obs);
      check("blinker_vertical", obs, (64'd1 << 2) | (64'd1 << 10) | (64'd1 << 18));
      run_gen(0, -1, 1'b0);
      read_board(obs);
      check("blinker_horizontal", obs, (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 11));

      // Block still life in one corner, lone cell in the opposite corner
      load_board(64'h0000_0000_0000_0303 | (64'd1 << 63));
      run_gen(0, -1, 1'b0);
      read_board(obs);
      check("block_and_corner", obs, 64'h0000_0000_0000_0303);

      // Step and frame_tick in the same cycle make one generation
      load_board({$urandom, $urandom});
      run_gen(0, -1, 1'b1);

      // Random boards with requests injected while busy
      for (int i = 0; i < 8; i++) begin
         load_board({$urandom, $urandom});
         run_gen(i % 5, $urandom_range(0, 64), 1'b0);
      end

      // load_en together with step in IDLE: load wins, no generation
      d          = {$urandom, $urandom};
      load_data  = d;
      load_en    = 1'b1;
      step       = 1'b1;
      tick();
      load_en    = 1'b0;
      step       = 1'b0;
      check("load_step_not_busy", busy, 0);
      pulses = 0;
      repeat (70) begin
         tick();
         if (gen_done) pulses++;
      end
      check("load_step_no_gen", pulses, 0);
      check("load_step_count", gen_count, 64'(exp_gc));
      model_board = d;
      read_board(obs);
      check("load_step_board", obs, d);

      // Auto-run: every second frame tick starts a generation
      load_board({$urandom, $urandom});
      run    = 1'b1;
      pulses = 0;
      for (int t = 0; t < 6; t++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         repeat (80) begin
            tick();
            if (gen_done) pulses++;
         end
      end
      check("auto_gen_pulses", pulses, 3);
      exp_gc += 3;
      check("auto_gen_count", gen_count, 64'(exp_gc));
      model_board = life_ref(life_ref(life_ref(model_board)));
      read_board(obs);
      check("auto_board", obs, model_board);

      // Frame counter holds while run is low
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      check("auto_first_tick_idle", busy, 0);
      run    = 1'b0;
      pulses = 0;
      for (int t = 0; t < 10; t++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         if (busy) pulses++;
         tick();
         if (gen_done || busy) pulses++;
      end
      check("run_low_no_gen", pulses, 0);
      run        = 1'b1;
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      check("fcnt_held_start", busy, 1);
      run    = 1'b0;
      pulses = 0;
      repeat (70) begin
         tick();
         if (gen_done) pulses++;
      end
      check("fcnt_held_one_gen", pulses, 1);
      exp_gc++;
      model_board = life_ref(model_board);
      read_board(obs);
      check("fcnt_held_board", obs, model_board);

      // Reset in the middle of COMPUTE
      load_board({$urandom, $urandom});
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (30) tick();
      check("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_reset_busy", busy, 0);
      check("mid_reset_gen_count", gen_count, 0);
      check("mid_reset_gen_done", gen_done, 0);
      rd_addr = 6'd3;
      #1;
      check("mid_reset_cell3", rd_cell, 1);
      rd_addr = 6'd10;
      #1;
      check("mid_reset_cell10", rd_cell, 0);
      read_board(obs);
      check("mid_reset_board", obs, 64'h8);
      rst_n       = 1'b1;
      exp_gc      = 0;
      model_board = 64'h8;
      tick();
      run_gen(0, -1, 1'b0);
      check("after_reset_board", model_board, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/life_engine.md
# life_engine

Game of Life generation engine for the VGA demo. It holds the displayed board, computes each new generation serially, one cell per clock, into a shadow bank, and commits the whole generation in a single cycle. It sits directly upstream of the pixel renderer, which reads cells through a combinational read port. The renderer therefore never sees a partially updated board.

## Interface
- BIT_WIDTH, 3: log2 of board width in cells.
- BIT_HEIGHT, 3: log2 of board height in cells.
- FRAMES_PER_GEN, 60: number of frame ticks between automatic generations while running.
- INIT_PATTERN, 64'h0000_0000_0000_0008: reset contents of the board; bit i is cell i.

Ports (SIZE = 2^(BIT_WIDTH+BIT_HEIGHT), AW = BIT_WIDTH+BIT_HEIGHT):
- clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blanking.
- run  in  1  level; enables automatic generations.
- step  in  1  one-cycle pulse; requests exactly one generation.
- load_en  in  1  one-cycle pulse; replaces the board with load_data.
- load_data  in  SIZE  new board image; bit i is cell i.
- rd_addr  in  AW  renderer cell address, {row, col}.
- rd_cell  out  1  combinational read: cur[rd_addr].
- busy  out  1  high while in COMPUTE or COMMIT.
- gen_done  out  1  one-cycle pulse after each commit.
- gen_count  out  16  generations committed since reset.

## Operation
- Cell index: i = row*2^BIT_WIDTH + col. Row 0 is the top row; col 0 is the left column.
- Storage: cur (displayed) and nxt (shadow), SIZE bits each.
- rd_cell always reads cur. It is never affected by nxt.
- Rule is B3/S23:
  - A live cell stays live with 2 or 3 live neighbours.
  - A dead cell becomes live with exactly 3 live neighbours.
  - All other cells become dead.
- Edges do not wrap. Cells outside the board count as dead.
- Neighbour count is 4 bits wide, range 0..8.
- FSM states: IDLE, COMPUTE, COMMIT.
  - IDLE, load_en=1: cur <= load_data and fcnt <= 0. load_en has priority over start in the same cycle.
  - IDLE, start: fcnt <= 0, idx <= 0, go to COMPUTE. start = step | (run & frame_tick & fcnt == FRAMES_PER_GEN-1).
  - IDLE, run & frame_tick & not start: fcnt <= fcnt+1.
  - IDLE, run=0: fcnt holds.
  - COMPUTE: nxt[idx] <= rule(cur, idx) and idx <= idx+1. When idx == SIZE-1, go to COMMIT.
  - COMMIT: cur <= nxt, gen_count <= gen_count+1, gen_done <= 1, go to IDLE.
- In COMPUTE and COMMIT, step, load_en and frame_tick are all ignored. No request is queued.
- Deasserting run in COMPUTE does not abort the generation; it completes.
- step and frame_tick arriving in the same cycle start one generation, not two.
- gen_count wraps from 16'hFFFF to 0.
- Reset values:
  - cur = INIT_PATTERN, nxt = 0.
  - state = IDLE, fcnt = 0, idx = 0.
  - busy = 0, gen_done = 0, gen_count = 0.
- Asserting rst_n low mid-COMPUTE immediately restores all reset values. Partial nxt contents are discarded.

## Timing
- start sampled at the edge ending cycle N.
- COMPUTE occupies cycles N+1 .. N+SIZE; that is 64 cycles for an 8x8 board.
- COMMIT occupies cycle N+SIZE+1.
- The new board is visible on rd_cell, and gen_done is high, in cycle N+SIZE+2.
- busy is high in cycles N+1 .. N+SIZE+1 and is registered.
- Total latency is SIZE+2 cycles, which fits well inside vertical blanking (45 lines).
- A load takes effect on rd_cell in the cycle after load_en.
- rd_cell has zero latency from rd_addr.
- The earliest a new start is accepted is cycle N+SIZE+2.

## Test plan
- Blinker: load cells 9, 10, 11; pulse step. Required: gen_done at cycle +66; cur then contains exactly cells 2, 10, 18; gen_count = 1. A second step restores 9, 10, 11.
- Still life and edges: load block 0, 1, 8, 9 plus a lone cell 63; pulse step. Required: block unchanged, cell 63 dead. Corner neighbour counting must not wrap to the opposite edge.
- Auto-run with FRAMES_PER_GEN=2 and run=1, 6 frame_ticks. Required: exactly 3 gen_done pulses. Then run=0 with 10 ticks: no gen_done, fcnt holds.
- Collisions:
  - step and frame_tick in the same cycle → exactly one generation.
  - step during busy → ignored.
  - load_en during busy → ignored; cur is unchanged until COMMIT.
  - load_en together with step in IDLE → board = load_data, no generation.
- Read isolation: sweep rd_addr across all 64 cells during COMPUTE. Required: rd_cell matches the pre-generation board in every cycle up to and including COMMIT.
- Reset mid-COMPUTE: drop rst_n at idx = 30. Required: immediately busy = 0, gen_count = 0, cur = INIT_PATTERN (only cell 3 live). After release, a step works normally.
